// File: rtl/md_unit.sv
// Multiply/divide unit owning HI/LO. MULT/MULTU/DIV/DIVU run for a fixed number of
// busy cycles and write HI/LO on the last one; MTHI/MTLO write in a single cycle.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic { IDLE, RUN } state_t;
    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_t;

    state_t        state;
    op_t           run_op;
    logic [31:0]   op_a;
    logic [31:0]   op_b;
    logic [CW-1:0] count;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] div_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign prod_s = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
    assign prod_u = {32'b0, op_a} * {32'b0, op_b};

    // Signed divide on magnitudes: also yields 0x80000000 / -1 = 0x80000000 rem 0.
    always_comb begin
        res_hi   = hi;
        res_lo   = lo;
        abs_a    = op_a[31] ? -op_a : op_a;
        abs_b    = op_b[31] ? -op_b : op_b;
        div_safe = (op_b == '0) ? 32'd1 : op_b;
        if (abs_b == '0) abs_b = 32'd1;
        q_mag    = abs_a / abs_b;
        r_mag    = abs_a % abs_b;
        case (run_op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                if (op_b != '0) begin
                    res_lo = (op_a[31] ^ op_b[31]) ? -q_mag : q_mag;
                    res_hi = op_a[31] ? -r_mag : r_mag;
                end
            end
            OP_DIVU: begin
                if (op_b != '0) begin
                    res_lo = op_a / div_safe;
                    res_hi = op_a % div_safe;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            count  <= '0;
            run_op <= OP_MULT;
            op_a   <= '0;
            op_b   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op_t'(op))
                            OP_MULT, OP_MULTU: begin
                                run_op <= op_t'(op);
                                op_a   <= src_a;
                                op_b   <= src_b;
                                count  <= CW'(MULT_CYCLES);
                                busy   <= 1'b1;
                                state  <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                run_op <= op_t'(op);
                                op_a   <= src_a;
                                op_b   <= src_b;
                                count  <= CW'(DIV_CYCLES);
                                busy   <= 1'b1;
                                state  <= RUN;
                            end
                            OP_MTHI: hi <= src_a;
                            OP_MTLO: lo <= src_a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (count == CW'(1)) begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        busy  <= 1'b0;
                        count <= '0;
                        state <= IDLE;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: driver pushes expected HI/LO and busy length per
// accepted instruction; a monitor pops and compares when the DUT presents the result.
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic        start   = 1'b0;
    logic [2:0]  op      = 3'd0;
    logic [31:0] src_a   = '0;
    logic [31:0] src_b   = '0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        bit          is_md;
        int          n;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;
    logic [31:0] mon_hi = '0;
    logic [31:0] mon_lo = '0;

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Architectural reference: 64-bit integer arithmetic, C-style truncating division.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] chi, input logic [31:0] clo,
                         output logic [31:0] nhi, output logic [31:0] nlo);
        longint          sa, sb, r64;
        longint unsigned ua, ub, u64;
        sa  = longint'(signed'(a));
        sb  = longint'(signed'(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        nhi = chi;
        nlo = clo;
        case (o)
            3'd0: begin r64 = sa * sb; nhi = r64[63:32]; nlo = r64[31:0]; end
            3'd1: begin u64 = ua * ub; nhi = u64[63:32]; nlo = u64[31:0]; end
            3'd2: if (b != 0) begin
                r64 = sa / sb; nlo = r64[31:0];
                r64 = sa % sb; nhi = r64[31:0];
            end
            3'd3: if (b != 0) begin
                u64 = ua / ub; nlo = u64[31:0];
                u64 = ua % ub; nhi = u64[31:0];
            end
            3'd4: nhi = a;
            3'd5: nlo = a;
            default: ;
        endcase
    endtask

    // Called at a negedge; holds start for exactly one cycle.
    task automatic pulse(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit use_fixed, input logic [31:0] fhi, input logic [31:0] flo);
        exp_t        e;
        logic [31:0] nhi, nlo;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        if (o <= 3'd5) begin
            model(o, a, b, ref_hi, ref_lo, nhi, nlo);
            if (use_fixed) begin
                nhi = fhi;
                nlo = flo;
            end
            e.is_md = (o <= 3'd3);
            e.n     = (o <= 3'd1) ? MULT_N : ((o <= 3'd3) ? DIV_N : 0);
            e.hi    = nhi;
            e.lo    = nlo;
            exp_q.push_back(e);
            ref_hi = nhi;
            ref_lo = nlo;
        end
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom);
        src_a = $urandom;
        src_b = $urandom;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (k >= 60) begin
            errors++;
            $display("FAIL busy_timeout: busy still %0d after %0d cycles, want 0", busy, k);
        end
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h1;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic random_ops(input int count);
        logic [2:0] o;
        for (int i = 0; i < count; i++) begin
            o = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            pulse(o, rnd_opnd(), rnd_opnd(), 1'b0, '0, '0);
            wait_idle();
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        exp_t e;
        int   cnt    = 0;
        int   waited = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                cnt    = 0;
                waited = 0;
                mon_hi = '0;
                mon_lo = '0;
            end else if (exp_q.size() == 0) begin
                check(busy == 1'b0 && hi == mon_hi && lo == mon_lo, "idle_hold",
                      $sformatf("got busy=%0d hi=%h lo=%h, want busy=0 hi=%h lo=%h",
                                busy, hi, lo, mon_hi, mon_lo));
            end else begin
                e = exp_q[0];
                if (!e.is_md) begin
                    check(busy == 1'b0 && hi == e.hi && lo == e.lo, "mt_write",
                          $sformatf("got busy=%0d hi=%h lo=%h, want busy=0 hi=%h lo=%h",
                                    busy, hi, lo, e.hi, e.lo));
                    mon_hi = e.hi;
                    mon_lo = e.lo;
                    void'(exp_q.pop_front());
                end else if (busy) begin
                    cnt++;
                    check(hi == mon_hi && lo == mon_lo, "busy_hold",
                          $sformatf("got hi=%h lo=%h during busy, want hi=%h lo=%h",
                                    hi, lo, mon_hi, mon_lo));
                end else if (cnt > 0) begin
                    check(cnt == e.n && waited == 0 && hi == e.hi && lo == e.lo, "md_result",
                          $sformatf("got hi=%h lo=%h busy_cycles=%0d late=%0d, want hi=%h lo=%h busy_cycles=%0d late=0",
                                    hi, lo, cnt, waited, e.hi, e.lo, e.n));
                    mon_hi = e.hi;
                    mon_lo = e.lo;
                    cnt    = 0;
                    waited = 0;
                    void'(exp_q.pop_front());
                end else begin
                    waited++;
                    if (waited > e.n + 4) begin
                        check(1'b0, "md_no_busy",
                              $sformatf("got no busy after %0d cycles, want busy for %0d", waited, e.n));
                        mon_hi = e.hi;
                        mon_lo = e.lo;
                        waited = 0;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check(busy == 1'b0 && hi == '0 && lo == '0, "reset_state",
              $sformatf("got busy=%0d hi=%h lo=%h, want 0/0/0", busy, hi, lo));
        reset_n = 1'b1;
        @(negedge clk);

        pulse(3'd0, 32'hFFFF_FFFE, 32'h3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        wait_idle();
        pulse(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
        wait_idle();
        pulse(3'd2, 32'hFFFF_FFF9, 32'h2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_idle();
        pulse(3'd3, 32'hFFFF_FFF9, 32'h2, 1'b1, 32'h0000_0001, 32'h7FFF_FFFC);
        wait_idle();
        pulse(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000);
        wait_idle();

        pulse(3'd4, 32'h1234_5678, $urandom, 1'b0, '0, '0);
        pulse(3'd5, 32'h9ABC_DEF0, $urandom, 1'b0, '0, '0);
        pulse(3'd2, $urandom, 32'h0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_idle();
        pulse(3'd3, $urandom, 32'h0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_idle();

        // Starts issued while busy must be ignored.
        pulse(3'd2, 32'd1000, 32'd7, 1'b0, '0, '0);
        @(negedge clk);
        start = 1'b1; op = 3'd0; src_a = $urandom; src_b = $urandom;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 3'd5; src_a = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        random_ops(60);

        // Asynchronous reset in the third busy cycle of a DIV.
        pulse(3'd2, $urandom, 32'd3, 1'b0, '0, '0);
        @(negedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        ref_hi = '0;
        ref_lo = '0;
        #1;
        check(busy == 1'b0 && hi == '0 && lo == '0, "async_reset",
              $sformatf("got busy=%0d hi=%h lo=%h, want 0/0/0", busy, hi, lo));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);

        random_ops(20);

        repeat (3) @(negedge clk);
        check(exp_q.size() == 0, "drain",
              $sformatf("got %0d pending results, want 0", exp_q.size()));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
